// File: rtl/ssd1306_seq_if.sv
// ssd1306_seq_if: byte handshake to the SPI serializer plus framebuffer read port
interface ssd1306_seq_if #(parameter int AW = 10);
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_dc;
  logic          tx_ready;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  modport master(output tx_valid, tx_byte, tx_dc, fb_addr, input tx_ready, fb_data);
  modport slave(input tx_valid, tx_byte, tx_dc, fb_addr, output tx_ready, fb_data);
endinterface

// File: rtl/ssd1306_seq.sv
// ssd1306_seq: SSD1306 reset/init/frame byte sequencer; define AUTO_REFRESH_EN for back-to-back frames without i_refresh
module ssd1306_seq #(
  parameter int RST_LOW_CYCLES  = 270,
  parameter int RST_WAIT_CYCLES = 2700,
  parameter int FB_BYTES        = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_lcd_rst,
  input  logic i_refresh,
  output logic o_init_done,
  output logic o_busy,
  ssd1306_seq_if.master tx
);
  localparam int AW = $clog2(FB_BYTES);
  localparam int CMAX = RST_LOW_CYCLES > RST_WAIT_CYCLES ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [7:0] INIT_ROM [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1,
    8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  localparam logic [7:0] ADDR_ROM [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  typedef enum logic [2:0] {S_RST_LOW, S_RST_WAIT, S_INIT, S_IDLE, S_ADDR, S_FETCH, S_SEND} state_t;
`ifdef AUTO_REFRESH_EN
  localparam state_t S_REST = S_ADDR;
`else
  localparam state_t S_REST = S_IDLE;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          hold_q, hold_d, done_q, done_d;
  logic          acc;
  assign acc = tx.tx_valid && tx.tx_ready;
  assign o_lcd_rst = state_q != S_RST_LOW;
  assign o_busy = state_q != S_IDLE;
  assign o_init_done = done_q;
  assign tx.fb_addr = addr_q;
  assign tx.tx_valid = state_q == S_INIT || state_q == S_ADDR || state_q == S_SEND;
  assign tx.tx_dc = state_q == S_SEND;
  // the RAM word is latched on the first SEND cycle so a stalled byte stays put whatever the RAM does
  assign tx.tx_byte = state_q == S_INIT ? INIT_ROM[idx_q] :
                      state_q == S_ADDR ? ADDR_ROM[idx_q] :
                      state_q == S_SEND ? (hold_q ? data_q : tx.fb_data) : 8'h00;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_RST_LOW;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    case (state_q)
      S_RST_LOW: begin
        cnt_d   = cnt_q == CW'(RST_LOW_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(RST_LOW_CYCLES - 1) ? S_RST_WAIT : S_RST_LOW;
      end
      S_RST_WAIT: begin
        cnt_d   = cnt_q == CW'(RST_WAIT_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(RST_WAIT_CYCLES - 1) ? S_INIT : S_RST_WAIT;
        idx_d   = '0;
      end
      S_INIT: if (acc) begin
        idx_d   = idx_q == 5'd24 ? '0 : idx_q + 1'b1;
        done_d  = idx_q == 5'd24;
        state_d = idx_q == 5'd24 ? S_REST : S_INIT;
      end
      S_IDLE: if (i_refresh) begin
        state_d = S_ADDR;
        idx_d   = '0;
      end
      S_ADDR: if (acc) begin
        idx_d   = idx_q == 5'd5 ? '0 : idx_q + 1'b1;
        addr_d  = '0;
        state_d = idx_q == 5'd5 ? S_FETCH : S_ADDR;
      end
      S_FETCH: begin
        hold_d  = 1'b0;
        state_d = S_SEND;
      end
      S_SEND: begin
        data_d = hold_q ? data_q : tx.fb_data;
        hold_d = 1'b1;
        if (acc) begin
          addr_d  = addr_q == AW'(FB_BYTES - 1) ? addr_q : addr_q + 1'b1;
          idx_d   = '0;
          state_d = addr_q == AW'(FB_BYTES - 1) ? S_REST : S_FETCH;
        end
      end
      default: state_d = S_RST_LOW;
    endcase
  end
endmodule

// File: tb/tb_ssd1306_seq.sv
// tb_ssd1306_seq: randomized-stall bench against a queue model of the expected accepted byte stream
module tb_ssd1306_seq;
  logic clk = 1'b0, rst = 1'b1, refresh = 1'b0;
  logic lcd_rst, init_done, busy;
  ssd1306_seq_if bus();
  ssd1306_seq dut(.i_clk(clk), .i_rst(rst), .o_lcd_rst(lcd_rst), .i_refresh(refresh),
                  .o_init_done(init_done), .o_busy(busy), .tx(bus));
  always #5 clk = ~clk;
  localparam logic [7:0] ROM [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1,
    8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  localparam logic [7:0] ACMD [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  logic [7:0] mem [1024];
  logic [8:0] q [$];
  logic [8:0] pend_v, e;
  logic [7:0] first_byte, last_data;
  int n_checks = 0, n_err = 0;
  int rcnt = 0, rise_t = -1, fv_t = -1, data_cnt = 0, init_left = 0, rdy_rand = 0;
  bit mdl_done = 0, pend = 0, seen = 0, rst_s = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    rst_s <= rst;
    seen <= 1'b1;
    bus.fb_data <= mem[bus.fb_addr];
  end
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.tx_ready = rdy_rand != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) if (seen) begin
    if (rst_s) begin
      chk("rst_valid", bus.tx_valid, 0);
      chk("rst_lcd_rst", lcd_rst, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      chk("rst_byte_dc", {bus.tx_dc, bus.tx_byte}, 0);
      chk("rst_fb_addr", bus.fb_addr, 0);
      q.delete();
      for (int i = 0; i < 25; i++) q.push_back({1'b0, ROM[i]});
      init_left = 25; mdl_done = 0; rcnt = 0; pend = 0; rise_t = -1; fv_t = -1; data_cnt = 0;
    end else begin
      rcnt++;
      chk("lcd_rst", lcd_rst, rcnt >= 270);
      if (lcd_rst && rise_t < 0) rise_t = rcnt;
      if (bus.tx_valid && fv_t < 0) begin fv_t = rcnt; first_byte = bus.tx_byte; end
      chk("init_done", init_done, mdl_done);
      chk("busy", busy, !(mdl_done && q.size() == 0));
      if (pend) begin
        chk("hold_valid", bus.tx_valid, 1);
        chk("hold_byte_dc", {bus.tx_dc, bus.tx_byte}, pend_v);
      end
      if (bus.tx_valid && q.size() == 0) chk("spurious_valid", bus.tx_valid, 0);
      if (refresh && mdl_done && q.size() == 0) begin
        for (int i = 0; i < 6; i++) q.push_back({1'b0, ACMD[i]});
        for (int a = 0; a < 1024; a++) q.push_back({1'b1, mem[a]});
        data_cnt = 0;
      end
      if (bus.tx_valid && bus.tx_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("tx_byte_dc", {bus.tx_dc, bus.tx_byte}, e);
        if (bus.tx_dc) begin data_cnt++; last_data = bus.tx_byte; end
        if (init_left > 0) begin init_left--; mdl_done = init_left == 0; end
      end
      pend = bus.tx_valid && !bus.tx_ready;
      pend_v = {bus.tx_dc, bus.tx_byte};
    end
  end
  task automatic step();
    @(posedge clk); #2;
  endtask
  task automatic pulse();
    refresh = 1'b1; step(); refresh = 1'b0;
  endtask
  task automatic wait_idle(int budget, string name);
    int n = 0;
    while (!(mdl_done && q.size() == 0) && n < budget) begin step(); n++; end
    chk({name, "_timeout"}, n < budget, 1);
  endtask
  task automatic wait_data(int k, string name);
    int n = 0;
    while (data_cnt < k && n < 20000) begin step(); n++; end
    chk({name, "_timeout"}, n < 20000, 1);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    repeat (3) step();
    rst = 1'b0;
    wait_idle(4000, "init");
    chk("rise_cycle", rise_t, 270);
    chk("first_valid_cycle", fv_t, 2970);
    chk("first_byte", first_byte, 8'hAE);
    chk("idle_busy", busy, 0);
    chk("idle_init_done", init_done, 1);
    pulse(); wait_idle(5000, "frame1");
    chk("frame1_count", data_cnt, 1024);
    chk("frame1_last", last_data, 8'hFF);
    rdy_rand = 1;
    pulse(); wait_idle(20000, "frame_stall");
    chk("stall_count", data_cnt, 1024);
    chk("stall_last", last_data, 8'hFF);
    pulse(); wait_data(300, "mid300");
    pulse(); wait_idle(20000, "frame_midreq");
    chk("midreq_count", data_cnt, 1024);
    repeat (30) step();
    chk("midreq_idle_busy", busy, 0);
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    pulse(); wait_idle(20000, "frame_rand");
    chk("rand_count", data_cnt, 1024);
    chk("rand_last", last_data, mem[1023]);
    rdy_rand = 0;
    pulse();
    for (int n = 0; n < 5000 && !(q.size() == 1 && bus.tx_valid); n++) step();
    refresh = 1'b1; step(); refresh = 1'b0;
    repeat (20) step();
    chk("final_accept_req_busy", busy, 0);
    chk("final_accept_req_count", data_cnt, 1024);
    rdy_rand = 1;
    pulse(); wait_data(500, "data500");
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_valid", bus.tx_valid, 0);
    chk("midrst_lcd_rst", lcd_rst, 0);
    chk("midrst_init_done", init_done, 0);
    wait_idle(10000, "reinit");
    chk("reinit_done", init_done, 1);
    chk("reinit_rise", rise_t, 270);
    pulse(); wait_idle(20000, "frame_after_rst");
    chk("after_rst_count", data_cnt, 1024);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
